// File: rtl/svm_sequencer.sv
// rtl/svm_sequencer.sv - SVM period sequencer: Z/A/B/Z vector schedule with per-segment dwell counting
// Define SVM_SEQ_ALTERNATE_EN to alternate A/B order by period parity.
module svm_sequencer #(
  parameter int         TW        = 12,
  parameter int         MIN_DWELL = 4,
  parameter logic [5:0] RST_VEC   = 6'b000011
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [TW-1:0] period,
  input  logic [TW-1:0] ta,
  input  logic [TW-1:0] tb,
  input  logic [5:0]    vec_a,
  input  logic [5:0]    vec_b,
  input  logic [5:0]    vec_z,
  input  logic          cur_dir,
  output logic [5:0]    vnew,
  output logic          dir,
  output logic [1:0]    seg,
  output logic          period_start,
  output logic          fault
);

  localparam logic [0:0]    S_IDLE = 1'b0;
  localparam logic [0:0]    S_RUN  = 1'b1;
  localparam logic [TW-1:0] MIN_D  = TW'(MIN_DWELL);
  localparam logic [TW-1:0] ONE    = TW'(1);

  logic [0:0]    state;
  logic [TW-1:0] cnt;
  logic [TW-1:0] dw [4];
  logic [5:0]    vv [4];
  logic          swap;

`ifdef SVM_SEQ_ALTERNATE_EN
  logic par;
  assign swap = par;
`else
  assign swap = 1'b0;
`endif

  logic [TW:0]   sum_ab, tz;
  logic [TW-1:0] z1, z2;
  logic          bad;
  logic [TW-1:0] ndw [4];
  logic [5:0]    nvv [4];
  logic [1:0]    fidx, nidx;
  logic          more, last, start;

  always_comb begin
    sum_ab = {1'b0, ta} + {1'b0, tb};
    tz     = {1'b0, period} - sum_ab;
    z1     = tz[TW:1];
    z2     = tz[TW-1:0] - z1;
    bad    = (sum_ab > {1'b0, period}) || (period < MIN_D);
    if (bad) begin
      ndw[0] = (period == '0) ? ONE : period;
      ndw[1] = '0;
      ndw[2] = '0;
      ndw[3] = '0;
      nvv[0] = vec_z;
      nvv[1] = vec_z;
      nvv[2] = vec_z;
      nvv[3] = vec_z;
    end else begin
      ndw[0] = z1;
      ndw[1] = swap ? tb : ta;
      ndw[2] = swap ? ta : tb;
      ndw[3] = z2;
      nvv[0] = vec_z;
      nvv[1] = swap ? vec_b : vec_a;
      nvv[2] = swap ? vec_a : vec_b;
      nvv[3] = vec_z;
    end
    // Lowest-indexed non-empty segment wins; empty ones are passed over in the same edge.
    fidx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (ndw[i] != '0) fidx = 2'(i);
    nidx = 2'd0;
    more = 1'b0;
    for (int i = 3; i >= 0; i--)
      if ((2'(i) > seg) && (dw[i] != '0)) begin
        nidx = 2'(i);
        more = 1'b1;
      end
    last  = (state == S_RUN) && (cnt == '0) && !more;
    start = en && ((state == S_IDLE) || last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      seg          <= '0;
      vnew         <= RST_VEC;
      dir          <= 1'b0;
      period_start <= 1'b0;
      fault        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        dw[i] <= '0;
        vv[i] <= '0;
      end
`ifdef SVM_SEQ_ALTERNATE_EN
      par <= 1'b0;
`endif
    end else begin
      period_start <= start;
      fault        <= start && bad;
      if (start) begin
        state <= S_RUN;
        for (int i = 0; i < 4; i++) begin
          dw[i] <= ndw[i];
          vv[i] <= nvv[i];
        end
        seg <= fidx;
        cnt <= ndw[fidx] - ONE;
        // Too-short segments keep the old vector so commutation always completes.
        if (ndw[fidx] >= MIN_D) begin
          vnew <= nvv[fidx];
          dir  <= cur_dir;
        end
`ifdef SVM_SEQ_ALTERNATE_EN
        par <= ~par;
`endif
      end else if (state == S_RUN) begin
        if (cnt != '0) begin
          cnt <= cnt - ONE;
        end else if (more) begin
          seg <= nidx;
          cnt <= dw[nidx] - ONE;
          if (dw[nidx] >= MIN_D) begin
            vnew <= vv[nidx];
            dir  <= cur_dir;
          end
        end else begin
          state <= S_IDLE;
`ifdef SVM_SEQ_ALTERNATE_EN
          par <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_svm_sequencer.sv
// tb/tb_svm_sequencer.sv - scoreboard bench for svm_sequencer
module tb_svm_sequencer;

  localparam logic [5:0] VA   = 6'b100101;
  localparam logic [5:0] VB   = 6'b110100;
  localparam logic [5:0] VZ   = 6'b111000;
  localparam logic [5:0] VRST = 6'b000011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [11:0] period = 12'd100;
  logic [11:0] ta = 12'd30;
  logic [11:0] tb = 12'd20;
  logic [5:0]  vec_a = VA;
  logic [5:0]  vec_b = VB;
  logic [5:0]  vec_z = VZ;
  logic        cur_dir = 1'b1;
  logic [5:0]  vnew;
  logic        dir;
  logic [1:0]  seg;
  logic        period_start;
  logic        fault;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0] v;
    logic [1:0] s;
    logic       d;
    logic       ps;
    logic       f;
  } exp_t;

  exp_t q[$];

  svm_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .ta(ta), .tb(tb),
    .vec_a(vec_a), .vec_b(vec_b), .vec_z(vec_z), .cur_dir(cur_dir),
    .vnew(vnew), .dir(dir), .seg(seg), .period_start(period_start), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, expv);
    end
  endtask

  task automatic push_seg(input logic [5:0] v, input logic [1:0] s, input int n,
                          input logic d, input logic ps, input logic f);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.v  = v;
      e.s  = s;
      e.d  = d;
      e.ps = (i == 0) ? ps : 1'b0;
      e.f  = (i == 0) ? f : 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_empty at %0t: observed 0 entries expected 1", $time);
      end else begin
        e = q.pop_front();
        chk("vnew", {2'b00, vnew}, {2'b00, e.v});
        chk("seg", {6'b0, seg}, {6'b0, e.s});
        chk("dir", {7'b0, dir}, {7'b0, e.d});
        chk("period_start", {7'b0, period_start}, {7'b0, e.ps});
        chk("fault", {7'b0, fault}, {7'b0, e.f});
      end
    end
  endtask

  initial begin
    // reset state
    @(posedge clk);
    #1;
    chk("rst_vnew", {2'b00, vnew}, {2'b00, VRST});
    chk("rst_seg", {6'b0, seg}, 8'd0);
    chk("rst_dir", {7'b0, dir}, 8'd0);
    chk("rst_ps", {7'b0, period_start}, 8'd0);
    chk("rst_fault", {7'b0, fault}, 8'd0);
    rst = 1'b0;
    en = 1'b1;

    // period 0 nominal, even
    push_seg(VZ, 2'd0, 25, 1'b1, 1'b1, 1'b0);
    push_seg(VA, 2'd1, 30, 1'b1, 1'b0, 1'b0);
    push_seg(VB, 2'd2, 20, 1'b1, 1'b0, 1'b0);
    push_seg(VZ, 2'd3, 25, 1'b1, 1'b0, 1'b0);
    run_cycles(100);

    // period 1 nominal, odd; inputs changed mid-period must be ignored
    push_seg(VZ, 2'd0, 25, 1'b1, 1'b1, 1'b0);
`ifdef SVM_SEQ_ALTERNATE_EN
    push_seg(VB, 2'd1, 20, 1'b1, 1'b0, 1'b0);
    push_seg(VA, 2'd2, 30, 1'b1, 1'b0, 1'b0);
`else
    push_seg(VA, 2'd1, 30, 1'b1, 1'b0, 1'b0);
    push_seg(VB, 2'd2, 20, 1'b1, 1'b0, 1'b0);
`endif
    push_seg(VZ, 2'd3, 25, 1'b1, 1'b0, 1'b0);
    run_cycles(50);
    ta = 12'd2;
    tb = 12'd20;
    run_cycles(50);

    // period 2: short A skipped, cur_dir toggled inside Z1
    push_seg(VZ, 2'd0, 39, 1'b1, 1'b1, 1'b0);
    push_seg(VZ, 2'd1, 2, 1'b1, 1'b0, 1'b0);
    push_seg(VB, 2'd2, 20, 1'b0, 1'b0, 1'b0);
    push_seg(VZ, 2'd3, 39, 1'b0, 1'b0, 1'b0);
    run_cycles(10);
    cur_dir = 1'b0;
    run_cycles(90);

    // period 3: invalid dwell
    cur_dir = 1'b1;
    ta = 12'd60;
    tb = 12'd50;
    push_seg(VZ, 2'd0, 100, 1'b1, 1'b1, 1'b1);
    run_cycles(100);

    // period 4: en dropped at cycle 40, then idle
    ta = 12'd30;
    tb = 12'd20;
    push_seg(VZ, 2'd0, 25, 1'b1, 1'b1, 1'b0);
    push_seg(VA, 2'd1, 30, 1'b1, 1'b0, 1'b0);
    push_seg(VB, 2'd2, 20, 1'b1, 1'b0, 1'b0);
    push_seg(VZ, 2'd3, 25, 1'b1, 1'b0, 1'b0);
    run_cycles(40);
    en = 1'b0;
    run_cycles(60);
    push_seg(VZ, 2'd3, 20, 1'b1, 1'b0, 1'b0);
    run_cycles(20);

    // restart from idle, then reset inside segment A
    en = 1'b1;
    push_seg(VZ, 2'd0, 25, 1'b1, 1'b1, 1'b0);
    push_seg(VA, 2'd1, 10, 1'b1, 1'b0, 1'b0);
    run_cycles(35);
    rst = 1'b1;
    #1;
    chk("async_vnew", {2'b00, vnew}, {2'b00, VRST});
    chk("async_seg", {6'b0, seg}, 8'd0);
    chk("async_dir", {7'b0, dir}, 8'd0);
    push_seg(VRST, 2'd0, 2, 1'b0, 1'b0, 1'b0);
    run_cycles(2);
    rst = 1'b0;
    push_seg(VZ, 2'd0, 25, 1'b1, 1'b1, 1'b0);
    push_seg(VA, 2'd1, 30, 1'b1, 1'b0, 1'b0);
    push_seg(VB, 2'd2, 20, 1'b1, 1'b0, 1'b0);
    push_seg(VZ, 2'd3, 25, 1'b1, 1'b0, 1'b0);
    run_cycles(100);
    en = 1'b0;

    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/svm_sequencer.md
# svm_sequencer

Schedules the switching vectors of one space-vector-modulation period and feeds them, one segment at a time, to the four-step commutation block (`vnew`/`dir` inputs). Each period it latches two active vectors, one zero vector and their dwell times. It splits the zero time around the active vectors, counts dwell in clock cycles and holds every issued vector long enough for a full commutation to complete. Sits between the SVM sector/dwell calculator and the commutator.

## Interface
- `TW`, 12: timer/dwell width in bits.
- `MIN_DWELL`, 4: minimum cycles a vector is held after a change; must be at least the commutation length (3 cycles).
- `RST_VEC`, 6'b000011: vector driven on `vnew` out of reset.
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: run request.
- `period` in TW: modulation period, in cycles.
- `ta`, `tb` in TW: dwell of active vectors A and B, in cycles.
- `vec_a`, `vec_b`, `vec_z` in 6: switch vectors A, B and zero.
- `cur_dir` in 1: load-current sign, forwarded as commutation direction.
- `vnew` out 6: vector to commutator.
- `dir` out 1: commutation direction to commutator.
- `seg` out 2: active segment index, 0..3.
- `period_start` out 1: one-cycle pulse on the first cycle of each period.
- `fault` out 1: one-cycle pulse, invalid dwell set for the period just started.

## Operation
- States: IDLE, RUN.
- **IDLE:** `en`=1 at an edge moves to RUN. That edge starts period 0, with parity cleared to even.
- **Period start:** at the starting edge, latch `period`, `ta`, `tb`, `vec_a`, `vec_b`, `vec_z`.
  - Compute tz = period−ta−tb at TW+1 bits, no wrap.
  - Z1 = floor(tz/2), Z2 = tz−Z1.
- **Segment order:**
  - Even parity: Z(Z1), A(ta), B(tb), Z(Z2).
  - Odd parity: Z(Z1), B(tb), A(ta), Z(Z2).
  - Parity toggles every period.
- **Vector issue:** at each segment's first edge, update `vnew` to the segment vector and sample `cur_dir` into `dir`.
- **Short segments:** a segment with 0 < dwell < MIN_DWELL is not issued. `vnew`/`dir` hold their previous value and the dwell still elapses, so the period length is preserved.
- **Zero-length segments:** consume no cycles and are skipped within the same edge.
- **Invalid dwell:** if ta+tb > period, or period < MIN_DWELL, pulse `fault`. The whole period runs `vec_z` as a single Z segment (`seg`=0) for max(period,1) cycles.
- **Period end:** at the last cycle, if `en`=1 the next period starts back-to-back. Otherwise go to IDLE; `vnew`, `dir` and `seg` hold their values.
- **`en` deasserted mid-period:** the current period always completes.
- **Reset:** `rst` in any state forces IDLE immediately.
  - `vnew`=RST_VEC, `dir`=0, `seg`=0, `period_start`=0, `fault`=0, parity even, counters 0.

## Timing
- `period_start`, `fault` and the first `vnew` update are all registered at the same edge that leaves IDLE or ends the prior period.
- A period occupies exactly `period` cycles; the next `period_start` follows `period` cycles later.
- `seg` changes at the same edge as the segment's `vnew` update. It also changes at the segment boundary when the segment is skipped.
- Consecutive `vnew` changes are always at least MIN_DWELL cycles apart.
- Inputs are only sampled at the period-start edge; changes mid-period are ignored.

## Configuration
- `SVM_SEQ_ALTERNATE_EN`
  - **Defined:** A/B order alternates by period parity, as above.
  - **Undefined:** every period uses Z, A, B, Z and parity logic is removed.

## Test plan
- **Nominal:** `period`=100, `ta`=30, `tb`=20, `en`=1.
  - Period 0: `vnew` = vec_z ×25, vec_a ×30, vec_b ×20, vec_z ×25.
  - Period 1: vec_z ×25, vec_b ×20, vec_a ×30, vec_z ×25.
  - `period_start` pulses exactly 100 cycles apart.
- **Short skip:** `ta`=2, `tb`=20, `period`=100 (tz=78).
  - vec_a is never driven.
  - `vnew` = vec_z for 41 cycles, then vec_b ×20, then vec_z ×39.
- **Fault:** `ta`=60, `tb`=50, `period`=100.
  - `fault` pulses with `period_start`.
  - `vnew` = vec_z for all 100 cycles.
- **Direction:** toggle `cur_dir` mid-segment.
  - `dir` changes only at the next issued vector edge.
- **Stop:** drop `en` at cycle 40 of a period.
  - The period finishes at cycle 100, then IDLE.
  - No further `period_start`; `vnew` holds vec_z.
- **Reset:** assert `rst` during segment A.
  - `vnew`=000011, `seg`=0 and `dir`=0 without waiting for a clock edge.
  - After release with `en`=1, the first period starts on even parity.
